// File: rtl/keccak_chi_inv_if.sv
// rtl/keccak_chi_inv_if.sv - state-in / state-out handshake bundle for keccak_chi_inv
interface keccak_chi_inv_if #(
    parameter int W = 64
);
    logic                      in_valid;
    logic                      in_ready;
    logic [4:0][4:0][W-1:0]    A_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [4:0][4:0][W-1:0]    A_out;

    modport master (
        output in_valid,
        output A_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  A_out
    );

    modport slave (
        input  in_valid,
        input  A_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output A_out
    );
endinterface

// File: rtl/keccak_chi_inv.sv
// rtl/keccak_chi_inv.sv - iterative inverse Keccak chi, one plane per cycle
module keccak_chi_inv #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          reset,
    keccak_chi_inv_if.slave bus
);
    typedef logic [4:0][4:0][W-1:0] state_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    function automatic logic [4:0] chi5(input logic [4:0] x);
        logic [4:0] y;
        y = '0;
        for (int i = 0; i < 5; i++) begin
            y[i] = x[i] ^ (~x[(i + 1) % 5] & x[(i + 2) % 5]);
        end
        return y;
    endfunction

    // chi5 is a permutation, so scattering every input to its image fills all 32 entries
    function automatic logic [31:0][4:0] build_inv_lut();
        logic [31:0][4:0] lut;
        lut = '0;
        for (int v = 0; v < 32; v++) begin
            lut[chi5(5'(v))] = 5'(v);
        end
        return lut;
    endfunction

    localparam logic [31:0][4:0] INV_LUT = build_inv_lut();

    logic [1:0] state_q, state_d;
    logic [2:0] p_q, p_d;
    state_t     st_q, st_d;
    state_t     a_out_q, a_out_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;

    logic [4:0] row;
    logic [4:0] inv_row;

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        st_d        = st_q;
        a_out_d     = a_out_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        row         = '0;
        inv_row     = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    st_d       = bus.A_in;
                    p_d        = 3'd0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                for (int j = 0; j < 5; j++) begin
                    if (p_q == 3'(j)) begin
                        for (int k = 0; k < W; k++) begin
                            for (int i = 0; i < 5; i++) begin
                                row[i] = st_q[i][j][k];
                            end
                            inv_row = INV_LUT[row];
                            for (int i = 0; i < 5; i++) begin
                                st_d[i][j][k] = inv_row[i];
                            end
                        end
                    end
                end
                if (p_q == 3'd4) begin
                    a_out_d     = st_d;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    p_d         = 3'd0;
                end else begin
                    p_d = p_q + 3'd1;
                end
            end
            HOLD: begin
                // in_ready only rises after leaving HOLD, so accept never overlaps output
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                p_d         = 3'd0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            p_q         <= 3'd0;
            st_q        <= '0;
            a_out_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            st_q        <= st_d;
            a_out_q     <= a_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.A_out     = a_out_q;
endmodule

// File: tb/tb_keccak_chi_inv.sv
// tb/tb_keccak_chi_inv.sv - self-checking bench for keccak_chi_inv
module tb_keccak_chi_inv;
    localparam int W = 64;
    typedef logic [4:0][4:0][W-1:0] state_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    keccak_chi_inv_if #(.W(W)) bus ();

    keccak_chi_inv #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward chi applied to the whole state straight from its defining formula
    function automatic state_t chi_state(input state_t x);
        state_t y;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < W; k++)
                    y[i][j][k] = x[i][j][k] ^ (~x[(i + 1) % 5][j][k] & x[(i + 2) % 5][j][k]);
        return y;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < W; k++)
                    s[i][j][k] = 1'($urandom);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t obs, input state_t exp);
        int fi, fj;
        total++;
        assert (obs === exp)
        else begin
            bad++;
            fi = 0;
            fj = 0;
            for (int i = 4; i >= 0; i--)
                for (int j = 4; j >= 0; j--)
                    if (obs[i][j] !== exp[i][j]) begin
                        fi = i;
                        fj = j;
                    end
            $error("FAIL %s lane[%0d][%0d] got=%h exp=%h", tag, fi, fj, obs[fi][fj], exp[fi][fj]);
        end
    endtask

    task automatic accept(input state_t s, input bit keep_valid);
        int n;
        bus.A_in     = s;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_case(input string tag, input state_t a_in, input state_t exp);
        int lat;
        accept(a_in, 1'b0);
        wait_out(lat);
        chk({tag, "_lat"}, lat, 32'd5);
        chk_state({tag, "_out"}, bus.A_out, exp);
        chk_state({tag, "_fwd"}, chi_state(bus.A_out), a_in);
        drain();
    endtask

    initial begin
        state_t zero_s, ones_s, row_in, row_exp, x1, x2;
        state_t xs[5];
        int     lat;
        int     ever_valid;
        int     c, ai, oi;
        int     acc_cyc[$];

        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A_in      = '0;
        zero_s = '0;
        ones_s = '1;

        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_state("rst_a_out", bus.A_out, zero_s);

        run_case("zero", zero_s, zero_s);
        run_case("ones", ones_s, ones_s);

        row_in  = '0;
        row_in[0][2] = 64'h1;
        row_in[3][2] = 64'h1;
        row_exp = '0;
        row_exp[0][2] = 64'h1;
        run_case("row", row_in, row_exp);
        run_case("ones2", ones_s, ones_s);

        // reset after two planes have been processed; that state must never surface
        x1 = rand_state();
        accept(chi_state(x1), 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk_state("midrst_a_out", bus.A_out, zero_s);
        tick();
        reset = 1'b1;
        ever_valid = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.out_valid) ever_valid = 1;
            tick();
        end
        chk("midrst_no_emit", ever_valid, 32'd0);
        chk_state("midrst_a_out_after", bus.A_out, zero_s);
        chk("midrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

        for (int r = 0; r < 200; r++) begin
            x1 = rand_state();
            run_case("rt", chi_state(x1), x1);
        end

        x1 = rand_state();
        x2 = rand_state();
        accept(chi_state(x1), 1'b1);
        bus.A_in = chi_state(x2);
        wait_out(lat);
        chk("bp_lat1", lat, 32'd5);
        for (int n = 0; n < 10; n++) begin
            chk_state("bp_hold_out", bus.A_out, x1);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("bp_lat2", lat, 32'd5);
        chk_state("bp_second", bus.A_out, x2);
        drain();

        for (int s = 0; s < 5; s++) xs[s] = rand_state();
        ai = 0;
        oi = 0;
        c  = 0;
        bus.A_in      = chi_state(xs[0]);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (oi < 5 && c < 100) begin
            logic acc;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (oi < 5) chk_state("b2b_out", bus.A_out, xs[oi]);
                oi++;
            end
            tick();
            if (acc) begin
                acc_cyc.push_back(c);
                ai++;
                if (ai < 5) bus.A_in = chi_state(xs[ai]);
                else bus.in_valid = 1'b0;
            end
            c++;
        end
        bus.in_valid  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.out_valid) oi++;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("b2b_out_count", oi, 32'd5);
        chk("b2b_acc_count", acc_cyc.size(), 32'd5);
        for (int s = 0; s < acc_cyc.size() && s < 5; s++)
            chk("b2b_acc_cycle", acc_cyc[s], 32'(7 * s));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keccak_chi_inv.md
# keccak_chi_inv

Iterative inverse of the Keccak χ step over a 5×5×W state. For every fixed plane index j and bit k, it treats the five-bit row A[0..4][j][k] as one χ output y and recovers the χ input x. The block is the decode-direction companion to the forward χ stage: χ(keccak_chi_inv(S)) = S for every state. It processes one plane per cycle behind a valid/ready handshake and is intended for inverse-round verification and test-vector regeneration.

## Interface
- W, default `w (from config_module.sv): lane width in bits.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  A_in holds a state to invert.
- in_ready  out  1  block can accept a state.
- A_in  in  [W-1:0] x [4:0][4:0]  χ-output state, indexed [i][j].
- out_valid  out  1  A_out holds the inverted state.
- out_ready  in  1  consumer accepts A_out.
- A_out  out  [W-1:0] x [4:0][4:0]  recovered χ-input state.

## Operation
- Forward χ definition, indices mod 5: y[i][j][k] = x[i][j][k] ^ (~x[i+1][j][k] & x[i+2][j][k]).
- Row vector: bit i of the 5-bit row is lane i, with j and k fixed.
- INV_LUT is a 32-entry, 5-bit table with INV_LUT[χ5(x)] = x.
  - It is built at elaboration by brute-force inversion of the 5-bit forward χ over all 32 inputs.
  - No runtime ROM load.
  - χ5 is a permutation, so every entry is defined.
- Internal registers:
  - st, a 5×5×W working state.
  - plane counter p, 3 bits.
  - FSM state.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: in_ready=1. On in_valid & in_ready, st <= A_in, p <= 0, go to RUN.
  - RUN: in_ready=0. Each cycle, for all k in 0..W-1, row st[0..4][p][k] <= INV_LUT[row]. Planes j≠p are untouched.
    - p increments.
    - When p==4 is processed: A_out <= updated st, out_valid <= 1, go to HOLD.
  - HOLD: out_valid=1, A_out stable. On out_ready, out_valid <= 0, go to IDLE.
- No simultaneous accept and output: in_ready is 0 in HOLD, even when out_ready=1 in the same cycle. A new state is accepted no earlier than the cycle after the HOLD→IDLE transition.
- in_valid is ignored outside IDLE, and A_in changes outside IDLE are ignored.
- A_out changes only on the RUN→HOLD transition and on reset.
- Reset, at any time including mid-RUN or in HOLD:
  - FSM goes to IDLE, p=0.
  - st=0, A_out=0, out_valid=0.
  - in_ready=1 as soon as reset deasserts.
  - A partially processed state is discarded and never emitted.
- No arithmetic beyond the table lookup. The counter p never exceeds 4.

## Timing
- Accept edge T, when in_valid & in_ready are both high.
- Planes 0..4 are processed on edges T+1..T+5.
- out_valid is high after edge T+5, so latency is 5 cycles from accept to out_valid.
- With out_ready held high, out_valid lasts exactly 1 cycle. in_ready returns high after edge T+6.
- Peak throughput is one state per 7 cycles.
- Backpressure: out_valid and A_out hold indefinitely until out_ready.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset values: assert reset mid-RUN (2 planes done) -> out_valid=0, in_ready=1, A_out all zero. That state never appears on A_out.
- Fixed points: A_in all lanes 0 -> A_out all 0. A_in all lanes all-ones -> A_out all-ones. out_valid rises exactly 5 cycles after accept.
- Single row, W=64: A_in[0][2]=1, A_in[3][2]=1, all else 0. This is row 5'b01001 at j=2, k=0, and χ5(00001)=01001.
  - Required: A_out[0][2]=1, every other lane 0.
- Round trip: 200 random states X. Feed A_in=χ(X), computed by the bench reference model -> A_out==X every time.
  - Also check that the forward χ block applied to A_out returns A_in.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid stays high with a second state.
  - A_out stable, in_ready=0 throughout, second state not accepted.
  - After out_ready pulses, the second state is accepted on the next IDLE cycle.
- Back-to-back: in_valid and out_ready held high for 5 states -> accepts at cycles 0, 7, 14, 21, 28, outputs in order with no loss or duplication.
